serial_subtractor: RTL and testbench

Multi-cycle two's-complement subtractor computing Diff = A − B − Bin, CHUNK bits per clock, with valid/ready handshakes on both sides. It is the inverse-operation companion to the team's ripple `full_adder` datapath. Its ripple-borrow chain is cut into registered chunks, so wide operands meet timing at the cost of latency. It sits in arithmetic pipelines where a producer hands over operand pairs and a consumer may apply backpressure on results.

---
 rtl/serial_subtractor.sv | 163 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Multi-cycle two's-complement subtractor computing
//            Diff = A - B - Bin, CHUNK bits per clock. The borrow chain is
//            cut into registered chunks so wide operands close timing at the
//            cost of WIDTH/CHUNK cycles of latency. Valid/ready handshake on
//            both the operand and the result side; one operation in flight.
// Ports    : clk        rising-edge clock
//            rst        asynchronous active-high reset
//            in_valid   operand pair present on A, B, Bin
//            in_ready   operand pair accepted this cycle when in_valid=1
//            A, B       minuend / subtrahend (WIDTH bits)
//            Bin        borrow-in
//            out_valid  result present on Diff, Bout, Ovf
//            out_ready  consumer takes the result this cycle
//            Diff       A - B - Bin modulo 2^WIDTH
//            Bout       unsigned borrow-out (A < B + Bin)
//            Ovf        signed overflow of A - B - Bin
// Revision : 1.0 - initial release
// ============================================================================

`ifndef W_COE
`define W_COE 8
`endif

module serial_subtractor #(
    parameter int WIDTH = `W_COE,
    parameter int CHUNK = 2     // WIDTH must be a multiple of CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0]    K_LAST   = KW'(N - 1);
    localparam logic [WIDTH-1:0] LSB_MASK = WIDTH'({CHUNK{1'b1}});

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               armed_q;
    logic [KW-1:0]      k_q, k_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic               bout_q, bout_d;
    logic               ovf_q, ovf_d;

    logic [31:0]        base;
    logic [CHUNK-1:0]   a_chunk;
    logic [CHUNK-1:0]   b_chunk;
    logic [CHUNK:0]     step;

    // armed_q holds in_ready low while in reset and releases it only on the
    // first clock edge after reset is removed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            armed_q  <= 1'b0;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            armed_q  <= 1'b1;
            k_q      <= k_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
        end
    end

    // Current chunk slice; shifts avoid oversized part-select indices.
    always_comb begin
        base    = 32'(k_q) * 32'(CHUNK);
        a_chunk = CHUNK'(a_q >> base);
        b_chunk = CHUNK'(b_q >> base);
        // CHUNK+1 bit subtraction: the MSB is the borrow into the next chunk.
        step    = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK{1'b0}}, borrow_q};
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d      = A;
                    b_d      = B;
                    borrow_d = Bin;
                    k_d      = '0;
                    state_d  = RUN;
                end
            end

            RUN: begin
                diff_d   = (diff_q & ~(LSB_MASK << base))
                         | (WIDTH'(step[CHUNK-1:0]) << base);
                borrow_d = step[CHUNK];
                k_d      = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    bout_d  = step[CHUNK];
                    // The last chunk holds the result MSB, so overflow is
                    // resolved on the same edge as the final borrow.
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                              (step[CHUNK-1] != a_q[WIDTH-1]);
                    state_d = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE) && armed_q;
    assign out_valid = (state_q == DONE);
    assign Diff      = diff_q;
    assign Bout      = bout_q;
    assign Ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Self-checking bench for serial_subtractor. Directed cases on an
//            8/2 instance, plus randomized traffic with output stalls on
//            five configurations compared against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed-test instance: WIDTH=8, CHUNK=2
    // ------------------------------------------------------------------
    logic       d_rst = 1'b1;
    logic       d_in_valid = 1'b0;
    logic       d_in_ready;
    logic [7:0] d_a = '0;
    logic [7:0] d_b = '0;
    logic       d_bin = 1'b0;
    logic       d_out_valid;
    logic       d_out_ready = 1'b0;
    logic [7:0] d_diff;
    logic       d_bout;
    logic       d_ovf;

    serial_subtractor #(.WIDTH(8), .CHUNK(2)) u_dut (
        .clk      (clk),
        .rst      (d_rst),
        .in_valid (d_in_valid),
        .in_ready (d_in_ready),
        .A        (d_a),
        .B        (d_b),
        .Bin      (d_bin),
        .out_valid(d_out_valid),
        .out_ready(d_out_ready),
        .Diff     (d_diff),
        .Bout     (d_bout),
        .Ovf      (d_ovf)
    );

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic bin, input logic [7:0] ed,
                          input logic eb, input logic eo, input string tag);
        int n;
        @(negedge clk);
        d_a = a; d_b = b; d_bin = bin; d_in_valid = 1'b1; d_out_ready = 1'b1;
        n = 0;
        while (!d_in_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        n = 0;
        while (!d_out_valid && n < 20) begin @(posedge clk); #1; n++; end
        check_val({tag, "_lat"},  n, 4);
        check_val({tag, "_diff"}, d_diff, ed);
        check_val({tag, "_bout"}, d_bout, eb);
        check_val({tag, "_ovf"},  d_ovf,  eo);
        check_val({tag, "_iready_in_done"}, d_in_ready, 0);
        @(posedge clk); #1;
        check_val({tag, "_ovalid_after"}, d_out_valid, 0);
        check_val({tag, "_iready_after"}, d_in_ready, 1);
    endtask

    // ------------------------------------------------------------------
    // Random configurations
    // ------------------------------------------------------------------
    logic rst_rand = 1'b1;

    for (genvar g = 0; g < 5; g++) begin : g_cfg
        localparam int W = (g == 4) ? 16 : 8;
        localparam int C = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 :
                           (g == 3) ? 8 : 4;
        localparam int N = W / C;

        logic         iv = 1'b0;
        logic         ir;
        logic         ov;
        logic         ordy = 1'b0;
        logic         bin = 1'b0;
        logic         bo;
        logic         of;
        logic [W-1:0] a = '0;
        logic [W-1:0] b = '0;
        logic [W-1:0] df;

        serial_subtractor #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk      (clk),
            .rst      (rst_rand),
            .in_valid (iv),
            .in_ready (ir),
            .A        (a),
            .B        (b),
            .Bin      (bin),
            .out_valid(ov),
            .out_ready(ordy),
            .Diff     (df),
            .Bout     (bo),
            .Ovf      (of)
        );

        initial begin
            logic [W-1:0] ed;
            logic         eb;
            logic         eo;
            longint       s;
            longint       smax;
            longint       smin;
            longint       ua;
            longint       ub;
            int           n;
            bit           took;
            string        p;
            p    = $sformatf("cfg%0d", g);
            smax = (longint'(1) <<< (W - 1)) - 1;
            smin = -(longint'(1) <<< (W - 1));
            wait (rst_rand == 1'b0);
            @(posedge clk); #1;
            for (int t = 0; t < 1000; t++) begin
                a   = W'($urandom);
                b   = W'($urandom);
                bin = 1'($urandom);
                iv  = 1'b1;
                n = 0;
                while (!ir && n < 20) begin @(negedge clk); n++; end
                if (n >= 20) check_val({p, "_accept_timeout"}, n, 0);
                @(posedge clk); #1;
                iv = 1'b0;

                // Reference: plain integer arithmetic on the operands.
                ua = longint'(a);
                ub = longint'(b);
                ed = W'(ua - ub - longint'(bin));
                eb = (ua < ub + longint'(bin));
                s  = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
                eo = (s > smax) || (s < smin);

                n = 0;
                while (!ov && n < 40) begin @(posedge clk); #1; n++; end
                check_val({p, "_lat"}, n, N);

                took = 1'b0;
                n = 0;
                while (!took && n < 60) begin
                    @(negedge clk);
                    check_val({p, "_ovalid"}, ov, 1);
                    check_val({p, "_diff"},   df, ed);
                    check_val({p, "_bout"},   bo, eb);
                    check_val({p, "_ovf"},    of, eo);
                    ordy = ($urandom_range(0, 2) != 0);
                    @(posedge clk);
                    took = ordy;
                    #1;
                    n++;
                end
                ordy = 1'b0;
                check_val({p, "_ovalid_drop"}, ov, 0);
            end
            n_done++;
        end
    end

    // ------------------------------------------------------------------
    // Directed sequence and summary
    // ------------------------------------------------------------------
    initial begin
        int n;
        #2;
        check_val("rst_in_ready",  d_in_ready,  0);
        check_val("rst_out_valid", d_out_valid, 0);
        check_val("rst_diff",      d_diff,      0);
        check_val("rst_bout",      d_bout,      0);
        check_val("rst_ovf",       d_ovf,       0);
        @(negedge clk);
        d_rst = 1'b0;
        rst_rand = 1'b0;
        #1;
        check_val("rel_in_ready_pre_edge", d_in_ready, 0);
        @(posedge clk); #1;
        check_val("rel_in_ready_post_edge", d_in_ready, 1);

        run_op(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, "basic");
        run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "wrap");
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "ovf");
        run_op(8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1, "ovf_bin");

        // Backpressure: result must hold while out_ready is low.
        @(negedge clk);
        d_a = 8'h10; d_b = 8'h20; d_bin = 1'b0; d_in_valid = 1'b1; d_out_ready = 1'b0;
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        n = 0;
        while (!d_out_valid && n < 20) begin @(posedge clk); #1; n++; end
        check_val("bp_lat", n, 4);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            d_a = 8'h55; d_b = 8'h00; d_in_valid = 1'b1;
            check_val("bp_ovalid", d_out_valid, 1);
            check_val("bp_diff",   d_diff, 8'hF0);
            check_val("bp_bout",   d_bout, 1);
            check_val("bp_ovf",    d_ovf,  0);
            check_val("bp_iready", d_in_ready, 0);
        end
        @(negedge clk);
        d_in_valid = 1'b0;
        d_out_ready = 1'b1;
        @(posedge clk); #1;
        check_val("bp_xfer_ovalid", d_out_valid, 0);
        check_val("bp_xfer_iready", d_in_ready, 1);
        @(posedge clk); #1;
        check_val("bp_no_queue_ovalid", d_out_valid, 0);
        check_val("bp_no_queue_iready", d_in_ready, 1);

        // Reset in the middle of an operation.
        @(negedge clk);
        d_a = 8'hFF; d_b = 8'h01; d_bin = 1'b0; d_in_valid = 1'b1;
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        d_rst = 1'b1;
        #1;
        check_val("mid_rst_in_ready",  d_in_ready,  0);
        check_val("mid_rst_out_valid", d_out_valid, 0);
        check_val("mid_rst_diff",      d_diff,      0);
        check_val("mid_rst_bout",      d_bout,      0);
        check_val("mid_rst_ovf",       d_ovf,       0);
        @(negedge clk);
        d_rst = 1'b0;
        @(posedge clk); #1;
        check_val("mid_rst_rel_iready", d_in_ready, 1);
        check_val("mid_rst_rel_ovalid", d_out_valid, 0);

        run_op(8'h0A, 8'h03, 1'b1, 8'h06, 1'b0, 1'b0, "after_rst");

        n = 0;
        while (n_done < 5 && n < 80000) begin @(posedge clk); n++; end
        check_val("random_cfgs_done", n_done, 5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
